// File: rtl/sequence_framer_tx_pkg.sv
// sequence_framer_tx_pkg: state encoding, default sync pattern and counter sizing
package sequence_framer_tx_pkg;
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SYNC = 2'd1,
        S_DATA = 2'd2,
        S_GAP  = 2'd3
    } state_t;
    localparam logic [3:0] DEF_PATTERN = 4'b1001;
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return $clog2(m + 1);
    endfunction
endpackage

// File: rtl/sequence_framer_tx_piso_shift.sv
// piso_shift: parallel-load, MSB-first shift register
module piso_shift #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic         i_shift,
    input  logic [W-1:0] i_data,
    output logic         o_msb
);
    logic [W-1:0] r_sr;
    // load wins over shift; each shift brings the next payload bit into the MSB
    always_ff @(posedge clk) begin
        if (rst) r_sr <= '0;
        else if (i_load) r_sr <= i_data;
        else if (i_shift) r_sr <= r_sr << 1;
    end
    assign o_msb = r_sr[W-1];
endmodule

// File: rtl/sequence_framer_tx.sv
// sequence_framer_tx: serial framer sending a sync pattern, an MSB-first payload and an idle gap
module sequence_framer_tx
    import sequence_framer_tx_pkg::*;
#(
    parameter int                PAT_W   = 4,
    parameter logic [PAT_W-1:0]  PATTERN = PAT_W'(DEF_PATTERN),
    parameter int                DATA_W  = 8,
    parameter int                GAP     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
    output logic              ready,
    output logic              tx,
    output logic              tx_valid,
    output logic              done
);
    localparam int CNT_W = cnt_width(PAT_W, DATA_W, GAP);
    state_t           r_state, w_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt, w_cm1;
    logic             r_tx, r_valid, r_done, r_ready;
    logic             w_tx, w_valid, w_done, w_load, w_shift, w_msb, w_pbit;

    piso_shift #(.W(DATA_W)) u_piso (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_shift (w_shift),
        .i_data  (data_in),
        .o_msb   (w_msb)
    );

    assign w_cm1  = r_cnt - 1'b1;
    assign w_pbit = |(PATTERN & (PAT_W'(1) << w_cm1));

    // next state and next output values; with GAP=0 ready rises on the last payload bit,
    // so an accepted start there chains the next frame with no idle cycle
    always_comb begin
        w_nxt   = S_IDLE;
        w_cnt   = '0;
        w_tx    = 1'b0;
        w_valid = 1'b0;
        w_done  = 1'b0;
        w_shift = 1'b0;
        w_load  = start && r_ready;
        case (r_state)
            S_SYNC: begin
                w_nxt   = (r_cnt == '0) ? S_DATA : S_SYNC;
                w_cnt   = (r_cnt == '0) ? CNT_W'(DATA_W - 1) : w_cm1;
                w_tx    = (r_cnt == '0) ? w_msb : w_pbit;
                w_valid = 1'b1;
                w_shift = (r_cnt == '0);
            end
            S_DATA: begin
                w_nxt   = (r_cnt != '0) ? S_DATA : (GAP != 0) ? S_GAP : S_IDLE;
                w_cnt   = (r_cnt != '0) ? w_cm1 : CNT_W'((GAP > 0) ? GAP - 1 : 0);
                w_tx    = (r_cnt != '0) && w_msb;
                w_valid = (r_cnt != '0);
                w_done  = (r_cnt == '0);
                w_shift = (r_cnt != '0);
            end
            S_GAP: begin
                w_nxt = (r_cnt == '0) ? S_IDLE : S_GAP;
                w_cnt = (r_cnt == '0) ? '0 : w_cm1;
            end
            default: w_nxt = S_IDLE;
        endcase
        if (w_load) begin
            w_nxt   = S_SYNC;
            w_cnt   = CNT_W'(PAT_W - 1);
            w_tx    = PATTERN[PAT_W-1];
            w_valid = 1'b1;
            w_shift = 1'b0;
        end
    end

    // state, counter and registered outputs; reset drops any frame in flight without done
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_tx    <= 1'b0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            r_ready <= 1'b1;
        end else begin
            r_state <= w_nxt;
            r_cnt   <= w_cnt;
            r_tx    <= w_tx;
            r_valid <= w_valid;
            r_done  <= w_done;
            r_ready <= (w_nxt == S_IDLE) || (GAP == 0 && w_nxt == S_DATA && w_cnt == '0);
        end
    end

    assign ready    = r_ready;
    assign tx       = r_tx;
    assign tx_valid = r_valid;
    assign done     = r_done;
endmodule

// File: tb/tb_sequence_framer_tx.sv
// tb_sequence_framer_tx: scoreboard bench for the sequence framer
module tb_sequence_framer_tx;
    localparam logic [3:0] PAT = 4'b1001;
    logic       clk = 1'b0;
    logic       rst = 1'b1, start = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       ready, tx, tx_valid, done;
    logic       rst_b = 1'b1, start_b = 1'b0;
    logic [3:0] data_b = 4'h0;
    logic       ready_b, tx_b, tx_valid_b, done_b;
    int         checks = 0, errors = 0, frames_done = 0, m_bits = 0;
    logic [11:0] m_frame = '0, m_exp;
    logic       m_rs;
    logic [3:0] pat_v = PAT;
    logic [11:0] q[$];

    always #5 clk = ~clk;

    sequence_framer_tx u_dut (
        .clk(clk), .rst(rst), .start(start), .data_in(data_in),
        .ready(ready), .tx(tx), .tx_valid(tx_valid), .done(done)
    );

    sequence_framer_tx #(.PAT_W(4), .PATTERN(4'b1001), .DATA_W(4), .GAP(0)) u_dut_b (
        .clk(clk), .rst(rst_b), .start(start_b), .data_in(data_b),
        .ready(ready_b), .tx(tx_b), .tx_valid(tx_valid_b), .done(done_b)
    );

    // deserialise every frame of the default instance and compare against the scoreboard
    always @(posedge clk) begin
        m_rs = rst;
        #1;
        if (m_rs) m_bits = 0;
        else begin
            checks += 2;
            if (tx_valid !== 1'b1 && tx !== 1'b0) begin errors++; $display("FAIL idle_tx: tx=%b, required 0", tx); end
            if (ready === 1'b1 && tx_valid === 1'b1) begin errors++; $display("FAIL ready_valid: both high, required exclusive"); end
            if (tx_valid === 1'b1) begin m_frame = {m_frame[10:0], tx}; m_bits++; end
            if (done === 1'b1) begin
                checks++;
                if (q.size() == 0) begin errors++; $display("FAIL unexpected_done: done=1, required no frame pending"); end
                else begin
                    m_exp = q.pop_front();
                    if (m_bits != 12 || m_frame !== m_exp) begin
                        errors++;
                        $display("FAIL frame: got %h (%0d bits), required %h (12 bits)", m_frame, m_bits, m_exp);
                    end
                end
                m_bits = 0;
                frames_done++;
            end else if (tx_valid !== 1'b1 && m_bits != 0) begin
                checks++; errors++;
                $display("FAIL frame_gap: tx_valid dropped after %0d bits, required 12 contiguous", m_bits);
                m_bits = 0;
            end
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready;
        int t = 0;
        while (ready !== 1'b1 && t < 40) begin step(); t++; end
        checks++;
        if (ready !== 1'b1) begin errors++; $display("FAIL ready_wait: ready=%b after %0d cycles, required 1", ready, t); end
    endtask

    task automatic launch(input logic [7:0] d);
        wait_ready();
        @(negedge clk);
        start = 1'b1;
        data_in = d;
        @(posedge clk);
        q.push_back({PAT, d});
        #1;
        start = 1'b0;
        data_in = ~d;
    endtask

    task automatic drain;
        int t = 0;
        while (q.size() != 0 && t < 100) begin step(); t++; end
        checks++;
        if (q.size() != 0) begin errors++; $display("FAIL drain: %0d frames pending, required 0", q.size()); end
    endtask

    task automatic test_reset;
        repeat (2) step();
        checks += 4;
        if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b, required 1", ready); end
        if (tx !== 1'b0) begin errors++; $display("FAIL reset_tx: got %b, required 0", tx); end
        if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, required 0", tx_valid); end
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b, required 0", done); end
        start = 1'b1;
        step();
        rst = 1'b0;
        start = 1'b0;
        checks++;
        if (tx_valid !== 1'b0 || ready !== 1'b1) begin errors++; $display("FAIL reset_start_drop: valid=%b ready=%b, required 0 1", tx_valid, ready); end
        step();
        checks++;
        if (tx_valid !== 1'b0 || ready !== 1'b1) begin errors++; $display("FAIL reset_start_queued: valid=%b ready=%b, required 0 1", tx_valid, ready); end
    endtask

    task automatic test_single;
        logic [11:0] f;
        f = {PAT, 8'hA5};
        launch(8'hA5);
        for (int n = 1; n <= 16; n++) begin
            checks += 4;
            if (tx_valid !== (n <= 12)) begin errors++; $display("FAIL single_valid[%0d]: got %b, required %b", n, tx_valid, n <= 12); end
            if (tx !== ((n <= 12) ? f[12-n] : 1'b0)) begin errors++; $display("FAIL single_tx[%0d]: got %b, required %b", n, tx, (n <= 12) ? f[12-n] : 1'b0); end
            if (done !== (n == 13)) begin errors++; $display("FAIL single_done[%0d]: got %b, required %b", n, done, n == 13); end
            if (ready !== (n >= 15)) begin errors++; $display("FAIL single_ready[%0d]: got %b, required %b", n, ready, n >= 15); end
            step();
        end
    endtask

    task automatic test_held;
        logic ev, er;
        wait_ready();
        @(negedge clk);
        start = 1'b1;
        data_in = 8'hFF;
        @(posedge clk);
        q.push_back({PAT, 8'hFF});
        #1;
        data_in = 8'h00;
        for (int n = 1; n <= 28; n++) begin
            ev = (n <= 12) || (n >= 16 && n <= 27);
            er = (n == 15);
            if (n == 15) q.push_back({PAT, 8'h00});
            if (n == 16) start = 1'b0;
            checks += 3;
            if (tx_valid !== ev) begin errors++; $display("FAIL held_valid[%0d]: got %b, required %b", n, tx_valid, ev); end
            if (ready !== er) begin errors++; $display("FAIL held_ready[%0d]: got %b, required %b", n, ready, er); end
            if (done !== (n == 13 || n == 28)) begin errors++; $display("FAIL held_done[%0d]: got %b, required %b", n, done, n == 13 || n == 28); end
            if (n <= 4 || (n >= 16 && n <= 19)) begin
                checks++;
                if (tx !== pat_v[3 - ((n - 1) % 15)]) begin errors++; $display("FAIL held_sync[%0d]: got %b, required %b", n, tx, pat_v[3 - ((n - 1) % 15)]); end
            end
            step();
        end
    endtask

    task automatic test_ignore;
        int nv = 0, nd = 0;
        launch(8'h3C);
        for (int n = 1; n <= 25; n++) begin
            if (n == 7) begin start = 1'b1; data_in = 8'hFF; end
            if (n == 8) start = 1'b0;
            if (tx_valid === 1'b1) nv++;
            if (done === 1'b1) nd++;
            step();
        end
        checks += 2;
        if (nv != 12) begin errors++; $display("FAIL ignore_valid_count: got %0d, required 12", nv); end
        if (nd != 1) begin errors++; $display("FAIL ignore_done_count: got %0d, required 1", nd); end
    endtask

    task automatic test_mid_reset;
        int nd = 0;
        launch(8'h5A);
        for (int n = 1; n <= 6; n++) begin
            checks++;
            if (tx_valid !== 1'b1) begin errors++; $display("FAIL abort_valid[%0d]: got %b, required 1", n, tx_valid); end
            if (n < 6) step();
        end
        rst = 1'b1;
        step();
        checks += 4;
        if (tx !== 1'b0) begin errors++; $display("FAIL abort_tx: got %b, required 0", tx); end
        if (tx_valid !== 1'b0) begin errors++; $display("FAIL abort_valid: got %b, required 0", tx_valid); end
        if (ready !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b, required 1", ready); end
        if (done !== 1'b0) begin errors++; $display("FAIL abort_done: got %b, required 0", done); end
        rst = 1'b0;
        q.delete();
        for (int n = 0; n < 15; n++) begin
            if (done === 1'b1) nd++;
            step();
        end
        checks++;
        if (nd != 0) begin errors++; $display("FAIL abort_late_done: got %0d pulses, required 0", nd); end
        launch(8'hC3);
        drain();
    endtask

    task automatic test_gap0;
        logic [7:0] f;
        f = 8'b1001_1001;
        step();
        rst_b = 1'b0;
        checks++;
        if (ready_b !== 1'b1) begin errors++; $display("FAIL gap0_reset_ready: got %b, required 1", ready_b); end
        @(negedge clk);
        start_b = 1'b1;
        data_b = 4'h9;
        step();
        for (int n = 1; n <= 40; n++) begin
            checks += 4;
            if (tx_valid_b !== 1'b1) begin errors++; $display("FAIL gap0_valid[%0d]: got %b, required 1", n, tx_valid_b); end
            if (tx_b !== f[7 - ((n - 1) % 8)]) begin errors++; $display("FAIL gap0_tx[%0d]: got %b, required %b", n, tx_b, f[7 - ((n - 1) % 8)]); end
            if (done_b !== (n > 1 && (n - 1) % 8 == 0)) begin errors++; $display("FAIL gap0_done[%0d]: got %b, required %b", n, done_b, n > 1 && (n - 1) % 8 == 0); end
            if (ready_b !== (n % 8 == 0)) begin errors++; $display("FAIL gap0_ready[%0d]: got %b, required %b", n, ready_b, n % 8 == 0); end
            step();
        end
        start_b = 1'b0;
    endtask

    task automatic test_random;
        int f0;
        f0 = frames_done;
        for (int i = 0; i < 1000; i++) launch(8'($urandom()));
        drain();
        checks++;
        if (frames_done - f0 != 1000) begin errors++; $display("FAIL random_frames: got %0d, required 1000", frames_done - f0); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_held();
        test_ignore();
        test_mid_reset();
        test_gap0();
        test_random();
        repeat (4) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
